xor_frame_checker: RTL and testbench

Parametrised, clocked successor to the team's two-input XOR primitive. Accepts a stream of WIDTH-bit words over a valid/ready handshake and folds each frame into a bitwise XOR checksum. On the frame's last word it presents checksum, overall parity bit, word count and an overflow flag on a second valid/ready handshake. Sits between a word source (test pattern generator or UART deframer) and the downstream integrity-check logic.

---
 rtl/xor_frame_checker_if.sv | 29 ++
 rtl/xor_frame_checker.sv | 100 ++++++++++
 tb/tb_xor_frame_checker.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/xor_frame_checker_if.sv
// Word-in / checksum-out handshake bundle for xor_frame_checker.
interface xor_frame_checker_if #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MAX_LEN = 16
);
  localparam int unsigned LW = $clog2(MAX_LEN + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             odd_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_parity;
  logic [LW-1:0]    out_len;
  logic             out_err;

  modport slave (
    input  in_valid, in_data, in_last, odd_mode, out_ready,
    output in_ready, out_valid, out_sum, out_parity, out_len, out_err
  );

  modport master (
    output in_valid, in_data, in_last, odd_mode, out_ready,
    input  in_ready, out_valid, out_sum, out_parity, out_len, out_err
  );
endinterface

// File: rtl/xor_frame_checker.sv
// Folds each frame of words into an XOR checksum and reports sum, parity,
// folded length and overflow on a result handshake.
module xor_frame_checker #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MAX_LEN = 16
) (
  input logic                clk,
  input logic                rst_n,
  xor_frame_checker_if.slave bus
);
  localparam int unsigned LW = $clog2(MAX_LEN + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state, state_d;
  logic [WIDTH-1:0] acc, acc_d, fold_acc, sum_d;
  logic [LW-1:0]    count, count_d, fold_cnt;
  logic             err, err_d, fold_err;
  logic             mode, mode_d;
  logic             accept, load;

  // Next state, folding rules and result capture.
  always_comb begin
    state_d  = state;
    acc_d    = acc;
    count_d  = count;
    err_d    = err;
    mode_d   = mode;
    fold_acc = acc;
    fold_cnt = count;
    fold_err = err;
    sum_d    = '0;
    load     = 1'b0;
    accept   = bus.in_valid && bus.in_ready;

    case (state)
      S_IDLE: state_d = S_ACC;
      S_ACC:  if (accept && bus.in_last) state_d = S_DONE;
      S_DONE: if (bus.out_valid && bus.out_ready) state_d = S_ACC;
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      if (count == '0) begin
        fold_acc = bus.in_data;
        fold_cnt = LW'(1);
        fold_err = 1'b0;
        mode_d   = bus.odd_mode;
      end else if (count < LW'(MAX_LEN)) begin
        fold_acc = acc ^ bus.in_data;
        fold_cnt = count + LW'(1);
      end else begin
        fold_err = 1'b1;
      end
      acc_d   = fold_acc;
      count_d = fold_cnt;
      err_d   = fold_err;
      // Frame complete: publish result and clear accumulators for the next frame.
      if (bus.in_last) begin
        load    = 1'b1;
        sum_d   = fold_acc ^ {WIDTH{mode_d}};
        acc_d   = '0;
        count_d = '0;
        err_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      acc            <= '0;
      count          <= '0;
      err            <= 1'b0;
      mode           <= 1'b0;
      bus.in_ready   <= 1'b0;
      bus.out_valid  <= 1'b0;
      bus.out_sum    <= '0;
      bus.out_parity <= 1'b0;
      bus.out_len    <= '0;
      bus.out_err    <= 1'b0;
    end else begin
      state         <= state_d;
      acc           <= acc_d;
      count         <= count_d;
      err           <= err_d;
      mode          <= mode_d;
      bus.in_ready  <= (state_d == S_ACC);
      bus.out_valid <= (state_d == S_DONE);
      if (load) begin
        bus.out_sum    <= sum_d;
        bus.out_parity <= ^sum_d;
        bus.out_len    <= fold_cnt;
        bus.out_err    <= fold_err;
      end
    end
  end
endmodule

// File: tb/tb_xor_frame_checker.sv
// Scoreboard bench for xor_frame_checker: directed scenarios then random frames.
module tb_xor_frame_checker;
  localparam int unsigned WIDTH   = 8;
  localparam int unsigned MAX_LEN = 4;
  localparam int unsigned LW      = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  xor_frame_checker_if #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) bus ();
  xor_frame_checker #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             par;
    logic [LW-1:0]    len;
    logic             err;
  } exp_t;

  exp_t             sb[$];
  logic [WIDTH-1:0] frame_q[$];
  int               checks   = 0;
  int               errors   = 0;
  logic             rand_rdy = 1'b0;
  logic             hold_rdy = 1'b1;
  logic             prev_v   = 1'b0;
  exp_t             held;
  exp_t             mon_e;

  function automatic void chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference: XOR of the first MAX_LEN words, inverted when the first word's mode is odd.
  task automatic push_model(input logic m0);
    exp_t        e;
    logic [WIDTH-1:0] s = '0;
    int unsigned n = frame_q.size();
    int unsigned k = (n < MAX_LEN) ? n : MAX_LEN;
    for (int unsigned i = 0; i < k; i++) s ^= frame_q[i];
    if (m0) s = ~s;
    e.sum = s;
    e.par = ^s;
    e.len = LW'(k);
    e.err = (n > MAX_LEN);
    sb.push_back(e);
  endtask

  task automatic send_word(input logic [WIDTH-1:0] d, input logic l, input logic m);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    bus.odd_mode = m;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) chk("in_ready_timeout", 32'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_frame(input logic m0, input int unsigned bub);
    int unsigned n = frame_q.size();
    push_model(m0);
    for (int unsigned i = 0; i < n; i++) begin
      if (i > 0 && bub > 0) begin
        int unsigned b = $urandom_range(0, bub);
        repeat (b) @(posedge clk);
        if (b > 0) #1;
      end
      send_word(frame_q[i], (i == n - 1), (i == 0) ? m0 : 1'($urandom_range(0, 1)));
    end
    chk("latency_valid", 32'(bus.out_valid), 1);
    chk("ready_drop", 32'(bus.in_ready), 0);
    frame_q.delete();
  endtask

  task automatic set_rdy(input logic v);
    @(negedge clk);
    hold_rdy = v;
    @(posedge clk);
    #2;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 0);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 0);
    chk({tag, "_out_sum"}, 32'(bus.out_sum), 0);
    chk({tag, "_out_parity"}, 32'(bus.out_parity), 0);
    chk({tag, "_out_len"}, 32'(bus.out_len), 0);
    chk({tag, "_out_err"}, 32'(bus.out_err), 0);
  endtask

  // Result consumer, changes only just after a rising edge.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : hold_rdy;
    end
  end

  // Monitor: stability while stalled, and scoreboard pop on each result handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (bus.out_valid) begin
        chk("in_ready_in_done", 32'(bus.in_ready), 0);
        if (prev_v) begin
          chk("hold_sum", 32'(bus.out_sum), 32'(held.sum));
          chk("hold_len", 32'(bus.out_len), 32'(held.len));
          chk("hold_err", 32'(bus.out_err), 32'(held.err));
        end
        held = '{bus.out_sum, bus.out_parity, bus.out_len, bus.out_err};
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result actual_sum=0x%0h required=no_result", bus.out_sum);
        end else begin
          mon_e = sb.pop_front();
          chk("out_sum", 32'(bus.out_sum), 32'(mon_e.sum));
          chk("out_parity", 32'(bus.out_parity), 32'(mon_e.par));
          chk("out_len", 32'(bus.out_len), 32'(mon_e.len));
          chk("out_err", 32'(bus.out_err), 32'(mon_e.err));
        end
      end
      prev_v = bus.out_valid;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n, d;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    bus.odd_mode = 1'b0;
    #2;
    chk_zero("reset");
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    chk("idle_in_ready", 32'(bus.in_ready), 0);
    @(posedge clk);
    #1;
    chk("acc_in_ready", 32'(bus.in_ready), 1);

    frame_q = '{8'hA5};                     send_frame(1'b0, 0);
    frame_q = '{8'h0F, 8'hF0, 8'h3C};       send_frame(1'b0, 0);
    frame_q = '{8'h0F, 8'hF0, 8'h3C};       send_frame(1'b1, 0);
    frame_q = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20}; send_frame(1'b0, 0);
    frame_q = '{8'h80};                     send_frame(1'b0, 0);

    // Bubbles then a stalled result.
    set_rdy(1'b0);
    frame_q = '{8'h11, 8'h22};
    push_model(1'b0);
    frame_q.delete();
    send_word(8'h11, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    send_word(8'h22, 1'b1, 1'b1);
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", 32'(bus.out_valid), 1);
    end
    @(negedge clk);
    hold_rdy = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("bp_release_in_ready", 32'(bus.in_ready), 1);
    chk("bp_release_valid", 32'(bus.out_valid), 0);

    // Reset in the middle of a frame.
    send_word(8'hFF, 1'b0, 1'b0);
    send_word(8'h0F, 1'b0, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    frame_q = '{8'h55}; send_frame(1'b0, 0);

    // Reset while a result is stalled.
    set_rdy(1'b0);
    frame_q = '{8'h12, 8'h34}; send_frame(1'b0, 0);
    #3;
    rst_n = 1'b0;
    #1;
    chk_zero("donerst");
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("no_stale_valid", 32'(bus.out_valid), 0);
    end
    set_rdy(1'b1);

    // Random frames, bubbles and result backpressure.
    rand_rdy = 1'b1;
    for (int f = 0; f < 40; f++) begin
      n = $urandom_range(1, 7);
      for (int unsigned i = 0; i < n; i++) begin
        d = $urandom;
        frame_q.push_back(8'(d));
      end
      send_frame(1'($urandom_range(0, 1)), 2);
    end

    n = 0;
    while (sb.size() > 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
